// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline slice.
package pipe_pkg;

    localparam int CTRL_W = 12;
    localparam logic [CTRL_W-1:0] CTRL_NOP = 12'h000;

    localparam int B_REGDST   = 0;
    localparam int B_ALUSRC   = 1;
    localparam int B_MEMTOREG = 2;
    localparam int B_REGWRITE = 3;
    localparam int B_MEMREAD  = 4;
    localparam int B_MEMWRITE = 5;
    localparam int B_BRANCH   = 6;
    localparam int B_JUMP     = 7;
    localparam int B_ALUOP_LO = 8;
    localparam int B_ALUOP_HI = 9;
    localparam int B_BEQ      = 10;
    localparam int B_ORI      = 11;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
        logic [31:0]       pc4;
        logic [31:0]       rd1;
        logic [31:0]       rd2;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } id_ex_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load in EX.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              ex_flush,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rt,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write
);

    logic uses_rt;
    logic hazard;
    logic unused_ctrl;

    assign unused_ctrl = ^{id_ctrl, ex_ctrl};

    assign uses_rt = id_ctrl[B_REGDST] | id_ctrl[B_MEMWRITE]
                   | id_ctrl[B_BEQ];

    assign hazard = ex_valid && ex_ctrl[B_MEMREAD]
                 && (ex_rt != 5'd0)
                 && ((ex_rt == id_rs)
                     || (uses_rt && (ex_rt == id_rt)));

    // A flush squashes the consumer, so it never needs to wait.
    assign stall      = hazard && id_valid && !ex_flush;
    assign pc_write   = !stall;
    assign ifid_write = !stall;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall control and stall counter.
module id_ex_pipe
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic [31:0]       id_pc4,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              ex_flush,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic [31:0]       ex_pc4,
    output logic [31:0]       ex_rd1,
    output logic [31:0]       ex_rd2,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [15:0]       stall_cnt
);

    id_ex_t      ex_q;
    id_ex_t      ex_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic        stall;
    logic        bubble;

    hazard_detect u_hazard (
        .id_ctrl    (id_ctrl),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_flush   (ex_flush),
        .ex_ctrl    (ex_q.ctrl),
        .ex_valid   (ex_q.valid),
        .ex_rt      (ex_q.rt),
        .stall      (stall),
        .pc_write   (pc_write),
        .ifid_write (ifid_write)
    );

    assign bubble = stall || ex_flush || !id_valid;

    always_comb begin
        ex_d       = ex_q;
        ex_d.pc4   = id_pc4;
        ex_d.rd1   = id_rd1;
        ex_d.rd2   = id_rd2;
        ex_d.imm   = id_imm;
        ex_d.rs    = id_rs;
        ex_d.rt    = id_rt;
        ex_d.rd    = id_rd;
        ex_d.ctrl  = bubble ? CTRL_NOP : id_ctrl;
        ex_d.valid = !bubble;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_ctrl   = ex_q.ctrl;
    assign ex_valid  = ex_q.valid;
    assign ex_pc4    = ex_q.pc4;
    assign ex_rd1    = ex_q.rd1;
    assign ex_rd2    = ex_q.rd2;
    assign ex_imm    = ex_q.imm;
    assign ex_rs     = ex_q.rs;
    assign ex_rt     = ex_q.rt;
    assign ex_rd     = ex_q.rd;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed table, reset and saturation
// sequences, then random traffic against an instruction-level model.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] id_ctrl;
    logic        id_valid;
    logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_flush;
    logic [11:0] ex_ctrl;
    logic        ex_valid;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        pc_write, ifid_write;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] LW  = 12'h01E;
    localparam logic [11:0] RF  = 12'h203;
    localparam logic [11:0] SW  = 12'h022;
    localparam logic [11:0] ORI = 12'h80A;
    localparam logic [11:0] BEQ = 12'h440;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_flush(ex_flush),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
        .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [11:0] ctrl;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        flush;
        logic        exp_pcw;
        logic [11:0] exp_ctrl;
        logic        exp_valid;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic drive(input logic [11:0] c, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic fl);
        id_ctrl  = c;
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = 5'($urandom);
        id_pc4   = $urandom;
        id_rd1   = $urandom;
        id_rd2   = $urandom;
        id_imm   = $urandom;
        ex_flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction-level view of what sits in EX.
    logic        m_valid;
    logic [11:0] m_ctrl;
    logic [4:0]  m_rt;
    int          m_cnt;

    function automatic logic model_stall();
        logic load_in_ex;
        logic reads_rt;
        load_in_ex = m_valid && m_ctrl[4] && (m_rt != 0);
        reads_rt   = id_ctrl[0] || id_ctrl[5] || id_ctrl[10];
        if (!load_in_ex || !id_valid || ex_flush) return 1'b0;
        return (m_rt == id_rs) || (reads_rt && (m_rt == id_rt));
    endfunction

    initial begin
        tbl[0]  = '{LW,  1, 1, 8, 0, 1, LW,   1, 0};
        tbl[1]  = '{RF,  1, 8, 9, 0, 0, 12'h0, 0, 1};
        tbl[2]  = '{RF,  1, 8, 9, 0, 1, RF,   1, 1};
        tbl[3]  = '{LW,  1, 2, 8, 0, 1, LW,   1, 1};
        tbl[4]  = '{SW,  1, 3, 8, 0, 0, 12'h0, 0, 2};
        tbl[5]  = '{SW,  1, 3, 8, 0, 1, SW,   1, 2};
        tbl[6]  = '{LW,  1, 0, 8, 0, 1, LW,   1, 2};
        tbl[7]  = '{ORI, 1, 3, 8, 0, 1, ORI,  1, 2};
        tbl[8]  = '{LW,  1, 0, 8, 0, 1, LW,   1, 2};
        tbl[9]  = '{RF,  1, 8, 9, 1, 1, 12'h0, 0, 2};
        tbl[10] = '{LW,  1, 0, 0, 0, 1, LW,   1, 2};
        tbl[11] = '{RF,  1, 0, 0, 0, 1, RF,   1, 2};
        tbl[12] = '{RF,  0, 8, 8, 0, 1, 12'h0, 0, 2};
        tbl[13] = '{BEQ, 1, 1, 5, 0, 1, BEQ,  1, 2};

        // Reset with garbage on the inputs.
        rst_n = 1'b0;
        drive(12'($urandom), 1'b1, 5'($urandom), 5'($urandom), 1'b0);
        #2;
        check("rst_ctrl", 32'(ex_ctrl), 0);
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_cnt", 32'(stall_cnt), 0);
        check("rst_pcw", 32'(pc_write), 1);
        for (int i = 0; i < 3; i++) begin
            drive(12'($urandom), 1'b1, 5'($urandom), 5'($urandom),
                  1'($urandom));
            tick();
        end
        check("rst_hold_ctrl", 32'(ex_ctrl), 0);
        check("rst_hold_valid", 32'(ex_valid), 0);
        check("rst_hold_ifid", 32'(ifid_write), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ctrl, tbl[i].valid, tbl[i].rs, tbl[i].rt,
                  tbl[i].flush);
            #1;
            check($sformatf("t%0d_pcw", i), 32'(pc_write), 32'(tbl[i].exp_pcw));
            check($sformatf("t%0d_ifid", i), 32'(ifid_write),
                  32'(tbl[i].exp_pcw));
            tick();
            check($sformatf("t%0d_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].exp_ctrl));
            check($sformatf("t%0d_valid", i), 32'(ex_valid),
                  32'(tbl[i].exp_valid));
            check($sformatf("t%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].exp_cnt));
            check($sformatf("t%0d_rt", i), 32'(ex_rt), 32'(tbl[i].rt));
        end

        // Reset asserted in the middle of a stall.
        drive(LW, 1'b1, 5'd0, 5'd8, 1'b0);
        tick();
        drive(RF, 1'b1, 5'd8, 5'd9, 1'b0);
        #1;
        check("mid_stall_pcw", 32'(pc_write), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ex_valid), 0);
        check("mid_rst_cnt", 32'(stall_cnt), 0);
        check("mid_rst_pcw", 32'(pc_write), 1);
        tick();
        check("mid_rst_hold", 32'(ex_ctrl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(RF, 1'b1, 5'd8, 5'd9, 1'b0);
        tick();
        check("post_rst_ctrl", 32'(ex_ctrl), 32'(RF));
        check("post_rst_valid", 32'(ex_valid), 1);
        check("post_rst_cnt", 32'(stall_cnt), 0);

        // Counter saturation.
        drive(LW, 1'b1, 5'd0, 5'd8, 1'b0);
        tick();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        for (int i = 0; i < 3; i++) begin
            drive(RF, 1'b1, 5'd8, 5'd9, 1'b0);
            #1;
            check($sformatf("sat%0d_pcw", i), 32'(pc_write), 0);
            tick();
            check($sformatf("sat%0d_cnt", i), 32'(stall_cnt), 32'hFFFF);
            drive(LW, 1'b1, 5'd0, 5'd8, 1'b0);
            tick();
        end

        // Random traffic against the model.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_ctrl  = '0;
        m_rt    = '0;
        m_cnt   = 0;
        for (int i = 0; i < 400; i++) begin
            logic [11:0] c;
            logic        st;
            logic [31:0] e_pc4, e_rd1, e_rd2, e_imm;
            logic [4:0]  e_rs, e_rd;
            c = 12'($urandom);
            if ($urandom_range(0, 1) == 0) c[4] = 1'b1;
            drive(c, ($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
            #1;
            st = model_stall();
            check("rnd_pcw", 32'(pc_write), 32'(!st));
            check("rnd_ifid", 32'(ifid_write), 32'(!st));
            e_pc4 = id_pc4; e_rd1 = id_rd1; e_rd2 = id_rd2; e_imm = id_imm;
            e_rs = id_rs; e_rd = id_rd;
            if (st || ex_flush || !id_valid) begin
                m_valid = 1'b0;
                m_ctrl  = '0;
            end else begin
                m_valid = 1'b1;
                m_ctrl  = id_ctrl;
            end
            m_rt = id_rt;
            if (st && m_cnt < 65535) m_cnt++;
            tick();
            check("rnd_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
            check("rnd_valid", 32'(ex_valid), 32'(m_valid));
            check("rnd_cnt", 32'(stall_cnt), 32'(m_cnt));
            check("rnd_pc4", ex_pc4, e_pc4);
            check("rnd_rd1", ex_rd1, e_rd1);
            check("rnd_rd2", ex_rd2, e_rd2);
            check("rnd_imm", ex_imm, e_imm);
            check("rnd_regs", {17'd0, ex_rs, ex_rt, ex_rd},
                  {17'd0, e_rs, m_rt, e_rd});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
